// File: rtl/rv_mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter and its helpers.
package rv_mem_arb_pkg;

   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned STRB_W           = 4;
   localparam int unsigned DEF_MAX_D_STREAK = 4;
   localparam int unsigned DEF_TIMEOUT      = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Attributes held stable on the memory port for the life of a transaction.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_cmd_t;

   // Counter width able to hold 0..max_val, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle counter: cleared on load, counts while enabled, flags expiry on the
// last allowed cycle. TIMEOUT = 0 disables expiry.
module arb_timeout_ctr
   import rv_mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = cnt_w(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_no_tmo
         assign expire_o = 1'b0;
      end else begin : g_tmo
         assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// with data priority, a fetch starvation guard, fetch-kill and access timeout.
module mem_port_arbiter
   import rv_mem_arb_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              if_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned   SW         = cnt_w(MAX_D_STREAK);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_t    state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          killed_q, killed_d;
   logic          req_q, req_d;
   mem_cmd_t      cmd_q, cmd_d;

   logic fetch_win;
   logic data_win;
   logic grant;
   logic grant_own;
   logic busy;
   logic tmo_expire;
   logic done;

   // Arbitration is only meaningful in IDLE; a kill that cycle vetoes fetch.
   assign fetch_win = (state_q == IDLE) && if_req && !if_kill &&
                      (!d_req || (streak_q == STREAK_MAX));
   assign data_win  = (state_q == IDLE) && d_req && !fetch_win;
   assign grant     = fetch_win || data_win;
   assign grant_own = fetch_win ? OWN_IF : OWN_D;
   assign busy      = (state_q != IDLE);
   assign done      = busy && (mem_ready || tmo_expire);

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (grant),
      .en_i     (busy),
      .expire_o (tmo_expire)
   );

   assign mem_req   = req_q;
   assign mem_we    = cmd_q.we;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;
   assign mem_wstrb = cmd_q.wstrb;

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      killed_d = killed_q;
      req_d    = req_q;
      cmd_d    = cmd_q;
      if_valid = 1'b0;
      if_err   = 1'b0;
      if_rdata = '0;
      d_valid  = 1'b0;
      d_err    = 1'b0;
      d_rdata  = '0;

      case (state_q)
         IDLE: begin
            if (fetch_win || !if_req) begin
               streak_d = '0;
            end else if (data_win && (streak_q != STREAK_MAX)) begin
               streak_d = streak_q + SW'(1);
            end
            if (grant) begin
               req_d = 1'b1;
               if (grant_own == OWN_IF) begin
                  state_d     = BUSY_IF;
                  cmd_d.we    = 1'b0;
                  cmd_d.addr  = if_addr;
                  cmd_d.wdata = '0;
                  cmd_d.wstrb = '0;
               end else begin
                  state_d     = BUSY_D;
                  cmd_d.we    = d_we;
                  cmd_d.addr  = d_addr;
                  cmd_d.wdata = d_wdata;
                  cmd_d.wstrb = d_wstrb;
               end
            end
         end

         BUSY_IF: begin
            if (if_kill) begin
               killed_d = 1'b1;
            end
            if (done) begin
               state_d  = IDLE;
               req_d    = 1'b0;
               killed_d = 1'b0;
               // A killed fetch still drains the memory but reports nothing.
               if (reset_n && !killed_q && !if_kill) begin
                  if_valid = 1'b1;
                  if_err   = !mem_ready;
                  if_rdata = mem_ready ? mem_rdata : '0;
               end
            end
         end

         BUSY_D: begin
            if (done) begin
               state_d = IDLE;
               req_d   = 1'b0;
               if (reset_n) begin
                  d_valid = 1'b1;
                  d_err   = !mem_ready;
                  d_rdata = mem_ready ? mem_rdata : '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
         killed_q <= 1'b0;
         req_q    <= 1'b0;
         cmd_q    <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         killed_q <= killed_d;
         req_q    <= req_d;
         cmd_q    <= cmd_d;
      end
   end

endmodule
